// File: rtl/uart_pkg.sv
// Shared definitions for the receive-UART register front end: register map,
// LSR layout, bus FSM encoding and the FIFO-empty sentinel.
package uart_pkg;

    localparam logic [1:0] REG_RBR = 2'd0;
    localparam logic [1:0] REG_LSR = 2'd1;
    localparam logic [1:0] REG_IER = 2'd2;

    localparam int LSR_AVAIL   = 0;
    localparam int LSR_ERR     = 1;
    localparam int LSR_TIMEOUT = 2;

    localparam logic [31:0] RX_EMPTY = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACK    = 2'd1,
        ST_SETTLE = 2'd2
    } bus_state_t;

    function automatic logic [31:0] lsr_word(input logic avail, input logic err, input logic tmo);
        logic [31:0] w;
        w              = '0;
        w[LSR_AVAIL]   = avail;
        w[LSR_ERR]     = err;
        w[LSR_TIMEOUT] = tmo;
        return w;
    endfunction

endpackage

// File: rtl/uart_rx_timeout.sv
// Character-timeout timer: a saturating down-counter that raises a sticky flag
// once data has sat unread in the FIFO for CYCLES clocks.
module uart_rx_timeout #(
    parameter int CYCLES = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic avail,
    input  logic restart,
    input  logic clear,
    output logic flag
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RELOAD;
            flag  <= 1'b0;
        end else begin
            if (!avail || restart) begin
                count <= RELOAD;
            end else if (count != '0) begin
                count <= count - 1'b1;
            end
            // Clearing takes priority: the reader has just serviced the FIFO.
            if (clear) begin
                flag <= 1'b0;
            end else if (avail && count == '0) begin
                flag <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_rx_regs.sv
// CPU-facing register block for the receive UART: turns bus reads into FIFO
// pops, keeps sticky error/timeout status and drives a level interrupt.
module uart_rx_regs
    import uart_pkg::*;
#(
    parameter int SYSTEM_CLK    = 100_000_000,
    parameter int BAUDRATE      = 9600,
    parameter int TIMEOUT_CHARS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [3:0]  mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    input  logic [31:0] rx_data,
    input  logic        rx_error,
    output logic        rx_rd,
    output logic        irq
);

    // Computed in 64 bits: chars * 10 * clk can exceed 2^31 at default settings.
    localparam longint TIMEOUT_LONG =
        longint'(TIMEOUT_CHARS) * longint'(10) * longint'(SYSTEM_CLK) / longint'(BAUDRATE);
    localparam int TIMEOUT_CYCLES = int'(TIMEOUT_LONG);

    bus_state_t  state, state_next;
    logic        armed;
    logic        pop_pend;
    logic [2:0]  ier;
    logic        err_sticky;
    logic        timeout_flag;
    logic [31:0] rdata_q;
    logic        irq_q;

    logic        rx_avail;
    logic [1:0]  sel;
    logic        is_write;
    logic        start;
    logic [31:0] read_value;
    logic        unused_bits;

    assign rx_avail    = (rx_data != RX_EMPTY);
    assign sel         = mem_addr[3:2];
    assign is_write    = |mem_wstrb;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:3]};

    // armed re-opens only after mem_valid has been seen low, so a held request
    // is never serviced twice.
    assign start = (state == ST_IDLE) && mem_valid && armed;

    always_comb begin
        read_value = '0;
        case (sel)
            REG_RBR: read_value = rx_data;
            REG_LSR: read_value = lsr_word(rx_avail, err_sticky, timeout_flag);
            REG_IER: read_value = {29'd0, ier};
            default: read_value = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_ACK;
            ST_ACK:    state_next = pop_pend ? ST_SETTLE : ST_IDLE;
            ST_SETTLE: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            armed      <= 1'b1;
            pop_pend   <= 1'b0;
            rdata_q    <= '0;
            ier        <= '0;
            err_sticky <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                armed <= 1'b0;
            end else if (!mem_valid) begin
                armed <= 1'b1;
            end
            if (start) begin
                rdata_q  <= read_value;
                pop_pend <= !is_write && (sel == REG_RBR) && rx_avail;
                if (is_write && sel == REG_IER) begin
                    ier <= mem_wdata[2:0];
                end
            end
            // A new error in the same cycle as the clearing LSR read wins.
            if (rx_error) begin
                err_sticky <= 1'b1;
            end else if (start && !is_write && sel == REG_LSR) begin
                err_sticky <= 1'b0;
            end
            irq_q <= (ier[0] & rx_avail) | (ier[1] & err_sticky) | (ier[2] & timeout_flag);
        end
    end

    // Gating with reset lets a reset landing in ACK suppress the handshake and pop.
    assign mem_ready = (state == ST_ACK) && !reset;
    assign rx_rd     = (state == ST_ACK) && pop_pend && !reset;
    assign mem_rdata = rdata_q;
    assign irq       = irq_q;

    uart_rx_timeout #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .reset   (reset),
        .avail   (rx_avail),
        .restart (start && sel == REG_RBR),
        .clear   (start && sel == REG_RBR && !is_write),
        .flag    (timeout_flag)
    );

endmodule

// File: tb/tb_uart_rx_regs.sv
// Directed bench for uart_rx_regs: a vector table for single accesses plus
// hand sequences for interrupt, timeout, back-to-back, held-valid and reset cases.
module tb_uart_rx_regs;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic        mem_ready;
    logic [3:0]  mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic [31:0] rx_data;
    logic        rx_error;
    logic        rx_rd;
    logic        irq;

    int checks = 0;
    int passed = 0;

    logic [7:0] fifo_mem [16];
    int wr_ptr = 0;
    int rd_ptr = 0;

    always #5 clk = ~clk;

    uart_rx_regs #(
        .SYSTEM_CLK    (1000),
        .BAUDRATE      (100),
        .TIMEOUT_CHARS (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wstrb (mem_wstrb),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .rx_data   (rx_data),
        .rx_error  (rx_error),
        .rx_rd     (rx_rd),
        .irq       (irq)
    );

    always_comb rx_data = (wr_ptr > rd_ptr) ? {24'd0, fifo_mem[rd_ptr[3:0]]} : 32'hFFFF_FFFF;

    always @(posedge clk) if (rx_rd) rd_ptr <= rd_ptr + 1;

    typedef struct {
        logic        push_en;
        logic [7:0]  push_byte;
        logic [3:0]  addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic        chk;
        logic [31:0] exp;
        int          pops;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic push(input logic [7:0] b);
        @(negedge clk);
        fifo_mem[wr_ptr[3:0]] = b;
        wr_ptr++;
    endtask

    task automatic bus(input int pre, input logic [3:0] addr, input logic [3:0] wstrb,
                       input logic [31:0] wdata, input logic err,
                       output logic [31:0] rdata, output int lat);
        repeat (pre) @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b1;
        mem_addr  = addr;
        mem_wstrb = wstrb;
        mem_wdata = wdata;
        rx_error  = err;
        lat       = 0;
        rdata     = '0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            rx_error = 1'b0;
            if (mem_ready) begin
                lat   = i;
                rdata = mem_rdata;
                break;
            end
        end
        mem_valid = 1'b0;
        mem_wstrb = 4'h0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          lat;
        int          p0;
        int          k;

        vecs[0]  = '{1'b1, 8'h41, 4'h0, 4'h0, 32'h0,         1'b1, 32'h0000_0041, 1};
        vecs[1]  = '{1'b0, 8'h00, 4'h4, 4'h0, 32'h0,         1'b1, 32'h0000_0000, 0};
        vecs[2]  = '{1'b0, 8'h00, 4'h0, 4'h0, 32'h0,         1'b1, 32'hFFFF_FFFF, 0};
        vecs[3]  = '{1'b0, 8'h00, 4'h8, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0,         0};
        vecs[4]  = '{1'b0, 8'h00, 4'h8, 4'h0, 32'h0,         1'b1, 32'h0000_0007, 0};
        vecs[5]  = '{1'b0, 8'h00, 4'h8, 4'h1, 32'h0000_0005, 1'b0, 32'h0,         0};
        vecs[6]  = '{1'b0, 8'h00, 4'hB, 4'h0, 32'h0,         1'b1, 32'h0000_0005, 0};
        vecs[7]  = '{1'b0, 8'h00, 4'hC, 4'hF, 32'hFFFF_FFFF, 1'b0, 32'h0,         0};
        vecs[8]  = '{1'b0, 8'h00, 4'hC, 4'h0, 32'h0,         1'b1, 32'h0000_0000, 0};
        vecs[9]  = '{1'b1, 8'h7E, 4'h6, 4'h0, 32'h0,         1'b1, 32'h0000_0001, 0};
        vecs[10] = '{1'b0, 8'h00, 4'h0, 4'hF, 32'h0000_0012, 1'b0, 32'h0,         0};
        vecs[11] = '{1'b0, 8'h00, 4'h1, 4'h0, 32'h0,         1'b1, 32'h0000_007E, 1};
        vecs[12] = '{1'b0, 8'h00, 4'h8, 4'hF, 32'h0,         1'b0, 32'h0,         0};
        vecs[13] = '{1'b0, 8'h00, 4'h8, 4'h0, 32'h0,         1'b1, 32'h0000_0000, 0};

        reset = 1'b1; mem_valid = 1'b0; mem_addr = 4'h0; mem_wstrb = 4'h0;
        mem_wdata = '0; rx_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_mem_ready", {31'd0, mem_ready}, 32'd0);
        check("reset_rx_rd", {31'd0, rx_rd}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mem_rdata", mem_rdata, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);

        for (int v = 0; v < 14; v++) begin
            if (vecs[v].push_en) push(vecs[v].push_byte);
            p0 = rd_ptr;
            bus(2, vecs[v].addr, vecs[v].wstrb, vecs[v].wdata, 1'b0, rd, lat);
            check($sformatf("vec%0d_latency", v), lat, 1);
            if (vecs[v].chk) check($sformatf("vec%0d_rdata", v), rd, vecs[v].exp);
            check($sformatf("vec%0d_pops", v), rd_ptr - p0, vecs[v].pops);
        end

        // Sticky error: set, read, cleared; then error coincident with the clearing read.
        @(negedge clk); rx_error = 1'b1;
        @(negedge clk); rx_error = 1'b0;
        bus(2, 4'h4, 4'h0, 32'h0, 1'b0, rd, lat);
        check("err_first_read", rd, 32'h2);
        bus(2, 4'h4, 4'h0, 32'h0, 1'b0, rd, lat);
        check("err_second_read", rd, 32'h0);
        bus(2, 4'h4, 4'h0, 32'h0, 1'b1, rd, lat);
        bus(2, 4'h4, 4'h0, 32'h0, 1'b0, rd, lat);
        check("err_set_wins", rd, 32'h2);
        bus(2, 4'h4, 4'h0, 32'h0, 1'b0, rd, lat);
        check("err_cleared_again", rd, 32'h0);

        // Data-ready interrupt.
        bus(2, 4'h8, 4'hF, 32'h1, 1'b0, rd, lat);
        push(8'h99);
        check("irq_before_avail", {31'd0, irq}, 32'd0);
        @(posedge clk); #1;
        check("irq_after_avail", {31'd0, irq}, 32'd1);
        bus(0, 4'h0, 4'h0, 32'h0, 1'b0, rd, lat);
        check("irq_rbr_data", rd, 32'h99);
        check("irq_held_through_pop", {31'd0, irq}, 32'd1);
        @(posedge clk); #1;
        check("irq_dropped", {31'd0, irq}, 32'd0);

        // Character timeout: 100 cycles, flag one edge later, irq one edge after that.
        bus(2, 4'h8, 4'hF, 32'h4, 1'b0, rd, lat);
        push(8'h33);
        k = 0;
        for (int i = 1; i <= 130; i++) begin
            @(posedge clk); #1;
            if (irq) begin k = i; break; end
        end
        check("timeout_irq_cycles", k, 102);
        bus(0, 4'h4, 4'h0, 32'h0, 1'b0, rd, lat);
        check("timeout_lsr", rd, 32'h5);
        bus(0, 4'h0, 4'h0, 32'h0, 1'b0, rd, lat);
        check("timeout_rbr", rd, 32'h33);
        bus(2, 4'h4, 4'h0, 32'h0, 1'b0, rd, lat);
        check("timeout_cleared", rd, 32'h0);
        check("timeout_irq_clear", {31'd0, irq}, 32'd0);
        bus(0, 4'h8, 4'hF, 32'h0, 1'b0, rd, lat);

        // Back-to-back reads: second request lands in SETTLE and waits one cycle.
        push(8'h10);
        push(8'h20);
        p0 = rd_ptr;
        bus(2, 4'h0, 4'h0, 32'h0, 1'b0, rd, lat);
        check("b2b_first", rd, 32'h10);
        bus(0, 4'h0, 4'h0, 32'h0, 1'b0, rd, lat);
        check("b2b_second", rd, 32'h20);
        check("b2b_second_latency", lat, 2);
        check("b2b_pops", rd_ptr - p0, 2);

        // Held mem_valid must not cause a second access.
        push(8'h61);
        push(8'h62);
        p0 = rd_ptr;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 4'h0; mem_wstrb = 4'h0;
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (mem_ready) begin k = i; break; end
        end
        check("held_latency", k, 1);
        repeat (6) @(posedge clk);
        #1;
        mem_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("held_single_pop", rd_ptr - p0, 1);
        bus(0, 4'h0, 4'h0, 32'h0, 1'b0, rd, lat);
        check("held_drain", rd, 32'h62);

        // Reset during the ACK cycle of an RBR read.
        bus(2, 4'h8, 4'hF, 32'h7, 1'b0, rd, lat);
        push(8'h55);
        p0 = rd_ptr;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 4'h0; mem_wstrb = 4'h0;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("rst_ack_no_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_ack_no_rd", {31'd0, rx_rd}, 32'd0);
        mem_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        check("rst_no_pop", rd_ptr - p0, 0);
        check("rst_out_ready", {31'd0, mem_ready}, 32'd0);
        check("rst_out_rdata", mem_rdata, 32'd0);
        check("rst_out_irq", {31'd0, irq}, 32'd0);
        bus(2, 4'h8, 4'h0, 32'h0, 1'b0, rd, lat);
        check("rst_ier_read", rd, 32'h0);
        bus(2, 4'h0, 4'h0, 32'h0, 1'b0, rd, lat);
        check("rst_drain", rd, 32'h55);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
